// File: rtl/systolic_mac_array.sv
// N x N output-stationary systolic matrix-multiply core: skews A columns / B rows into signed MAC PEs,
// then drains C row-major. Define SYSTOLIC_SATURATE_EN for saturating instead of wrapping accumulation.
module systolic_mac_array #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20,
  localparam int unsigned IdxW  = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                in_last_i,
  input  logic [N*DATA_W-1:0] a_vec_i,
  input  logic [N*DATA_W-1:0] b_vec_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_W-1:0]    out_data_o,
  output logic [IdxW-1:0]     out_idx_o,
  output logic                busy_o
);

  localparam int unsigned CntW = $clog2(2 * N);

  typedef enum logic [1:0] {StAccum, StFlush, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            clear_acc;
  logic            accept;

  // Skew delay lines: row/column x is tapped after x register stages.
  logic signed [DATA_W-1:0] a_sk_q [N][N];
  logic signed [DATA_W-1:0] b_sk_q [N][N];
  logic                     a_skv_q [N][N];
  logic                     b_skv_q [N][N];
  logic signed [DATA_W-1:0] a_line [N][N];
  logic signed [DATA_W-1:0] b_line [N][N];
  logic                     a_linev [N][N];
  logic                     b_linev [N][N];

  // PE operand registers and their west/north feeds.
  logic signed [DATA_W-1:0] a_q [N][N];
  logic signed [DATA_W-1:0] b_q [N][N];
  logic                     av_q [N][N];
  logic                     bv_q [N][N];
  logic signed [DATA_W-1:0] a_west [N][N];
  logic signed [DATA_W-1:0] b_north [N][N];
  logic                     a_westv [N][N];
  logic                     b_northv [N][N];

  logic signed [ACC_W-1:0]  acc_q [N][N];
  logic signed [ACC_W-1:0]  acc_d [N][N];
  logic signed [ACC_W-1:0]  acc_flat [N*N];

  assign accept      = in_valid_i && (state_q == StAccum);
  assign in_ready_o  = (state_q == StAccum);
  assign out_valid_o = (state_q == StDrain);
  assign busy_o      = (state_q != StAccum);
  assign out_idx_o   = idx_q;
  assign out_data_o  = out_valid_o ? acc_flat[idx_q] : '0;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    idx_d       = idx_q;
    clear_acc   = 1'b0;
    unique case (state_q)
      StAccum: begin
        if (in_valid_i && in_last_i) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
        end
      end
      StFlush: begin
        if (flush_cnt_q == CntW'(2 * N - 2)) begin
          state_d = StDrain;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (out_ready_i) begin
          if (idx_q == IdxW'(N * N - 1)) begin
            idx_d     = '0;
            state_d   = StAccum;
            clear_acc = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_line[i][0]  = accept ? a_vec_i[i*DATA_W +: DATA_W] : '0;
      a_linev[i][0] = accept;
      b_line[i][0]  = accept ? b_vec_i[i*DATA_W +: DATA_W] : '0;
      b_linev[i][0] = accept;
      for (int d = 1; d < N; d++) begin
        a_line[i][d]  = a_sk_q[i][d-1];
        a_linev[i][d] = a_skv_q[i][d-1];
        b_line[i][d]  = b_sk_q[i][d-1];
        b_linev[i][d] = b_skv_q[i][d-1];
      end
    end
    for (int i = 0; i < N; i++) begin
      a_west[i][0]   = a_line[i][i];
      a_westv[i][0]  = a_linev[i][i];
      b_north[0][i]  = b_line[i][i];
      b_northv[0][i] = b_linev[i][i];
      for (int j = 1; j < N; j++) begin
        a_west[i][j]   = a_q[i][j-1];
        a_westv[i][j]  = av_q[i][j-1];
        b_north[j][i]  = b_q[j-1][i];
        b_northv[j][i] = bv_q[j-1][i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic signed [2*DATA_W-1:0] prod;
        logic signed [ACC_W-1:0]    ext;
        logic signed [ACC_W-1:0]    nxt;
`ifdef SYSTOLIC_SATURATE_EN
        logic signed [ACC_W:0]      sum;
`endif
        prod = (2 * DATA_W)'(a_q[i][j]) * (2 * DATA_W)'(b_q[i][j]);
        ext  = ACC_W'(prod);
`ifdef SYSTOLIC_SATURATE_EN
        sum = (ACC_W + 1)'(acc_q[i][j]) + (ACC_W + 1)'(ext);
        // Sign bits disagree only when the ACC_W-bit result overflowed.
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          nxt = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
          nxt = sum[ACC_W-1:0];
        end
`else
        nxt = acc_q[i][j] + ext;
`endif
        acc_d[i][j] = acc_q[i][j];
        if (clear_acc) begin
          acc_d[i][j] = '0;
        end else if (av_q[i][j] && bv_q[i][j]) begin
          acc_d[i][j] = nxt;
        end
        acc_flat[i*N+j] = acc_q[i][j];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StAccum;
      flush_cnt_q <= '0;
      idx_q       <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_sk_q[i][j]  <= '0;
          b_sk_q[i][j]  <= '0;
          a_skv_q[i][j] <= 1'b0;
          b_skv_q[i][j] <= 1'b0;
          a_q[i][j]     <= '0;
          b_q[i][j]     <= '0;
          av_q[i][j]    <= 1'b0;
          bv_q[i][j]    <= 1'b0;
          acc_q[i][j]   <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      idx_q       <= idx_d;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_sk_q[i][j]  <= a_line[i][j];
          b_sk_q[i][j]  <= b_line[i][j];
          a_skv_q[i][j] <= a_linev[i][j];
          b_skv_q[i][j] <= b_linev[i][j];
          a_q[i][j]     <= a_west[i][j];
          b_q[i][j]     <= b_north[i][j];
          av_q[i][j]    <= a_westv[i][j];
          bv_q[i][j]    <= b_northv[i][j];
          acc_q[i][j]   <= acc_d[i][j];
        end
      end
    end
  end

endmodule
